// File: rtl/act_pkg.sv
// Shared types and helpers for the multi-lane activation unit.
// Activation mode encoding and a popcount over per-lane clamp flags.
package act_pkg;

    typedef enum logic [1:0] {
        ACT_PASS  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLIP  = 2'd3
    } act_mode_e;

    // Flags are zero-extended to this width before counting; LANES must not exceed it.
    localparam int MAX_LANES = 32;

    function automatic logic [5:0] popcount(input logic [MAX_LANES-1:0] flags);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {5'd0, flags[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/act_lane.sv
// One lane of the activation function, purely combinational.
// Flags a lane as clamped when RELU/CLIP force a nonzero input to zero.
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  act_mode_e                    mode,
    input  logic signed [DATA_WIDTH-1:0] cap,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         clamped
);

    logic x_neg;
    logic cap_nonpos;

    assign x_neg      = x[DATA_WIDTH-1];
    assign cap_nonpos = cap[DATA_WIDTH-1] || (cap == '0);

    always_comb begin
        y       = x;
        clamped = 1'b0;
        case (mode)
            ACT_PASS: begin
                y = x;
            end
            ACT_RELU: begin
                if (x_neg) begin
                    y       = '0;
                    clamped = 1'b1;
                end
            end
            ACT_LEAKY: begin
                // Arithmetic shift floors toward minus infinity and cannot overflow.
                if (x_neg) begin
                    y = x >>> LEAK_SHIFT;
                end
            end
            ACT_CLIP: begin
                if (x_neg || cap_nonpos) begin
                    y       = '0;
                    clamped = (x != '0);
                end else if (x > cap) begin
                    y = cap;
                end
            end
            default: begin
                y = x;
            end
        endcase
    end

endmodule

// File: rtl/act_unit_mc.sv
// Two-stage multi-lane activation pipeline with valid/ready backpressure
// and a saturating count of lanes forced to zero.
module act_unit_mc
    import act_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACTION    = 14,
    parameter int LANES       = 4,
    parameter int LEAK_SHIFT  = 3,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic [1:0]                  in_mode,
    input  logic [DATA_WIDTH-1:0]       in_cap,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [COUNT_WIDTH-1:0]      clamp_count,
    input  logic                        count_clr
);

    localparam int BUS_W = LANES * DATA_WIDTH;
    localparam int SUM_W = ((COUNT_WIDTH > 6) ? COUNT_WIDTH : 6) + 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic                   s1_en;
    logic                   s2_en;

    logic                   s1_valid_q;
    logic [BUS_W-1:0]       s1_data_q;
    act_mode_e              s1_mode_q;
    logic [DATA_WIDTH-1:0]  s1_cap_q;

    logic                   s2_valid_q;
    logic [BUS_W-1:0]       s2_data_q;
    logic [BUS_W-1:0]       s2_data_d;

    logic [LANES-1:0]       clamp_flags;
    logic [5:0]             clamp_pop;
    logic [SUM_W-1:0]       count_sum;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en && !rst;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            act_lane #(
                .DATA_WIDTH(DATA_WIDTH),
                .LEAK_SHIFT(LEAK_SHIFT)
            ) u_lane (
                .x      (s1_data_q[gi*DATA_WIDTH +: DATA_WIDTH]),
                .mode   (s1_mode_q),
                .cap    (s1_cap_q),
                .y      (s2_data_d[gi*DATA_WIDTH +: DATA_WIDTH]),
                .clamped(clamp_flags[gi])
            );
        end
    endgenerate

    assign clamp_pop = popcount(MAX_LANES'(clamp_flags));
    assign count_sum = SUM_W'(count_q) + SUM_W'(clamp_pop);

    // Clear wins over a same-cycle increment; the increment saturates at all-ones.
    always_comb begin
        count_d = count_q;
        if (count_clr) begin
            count_d = '0;
        end else if (s2_en && s1_valid_q) begin
            if (count_sum > SUM_W'(CNT_MAX)) begin
                count_d = CNT_MAX;
            end else begin
                count_d = count_sum[COUNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= ACT_PASS;
            s1_cap_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            count_q    <= '0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= in_valid && in_ready;
                s1_data_q  <= in_data;
                s1_mode_q  <= act_mode_e'(in_mode);
                s1_cap_q   <= in_cap;
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                s2_data_q  <= s2_data_d;
            end
            count_q <= count_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_data    = s2_data_q;
    assign clamp_count = count_q;

endmodule

// File: tb/tb_act_unit_mc.sv
// Directed bench for act_unit_mc: modes, latency, backpressure, counter edges, reset.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_act_unit_mc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_mode;
    logic [15:0] in_cap;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [31:0] clamp_count;
    logic        count_clr;

    logic        sm_in_ready;
    logic        sm_out_valid;
    logic [63:0] sm_out_data;
    logic [3:0]  sm_count;

    int total = 0;
    int bad   = 0;

    act_unit_mc #(
        .DATA_WIDTH(16), .FRACTION(14), .LANES(4), .LEAK_SHIFT(3), .COUNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_cap(in_cap),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .clamp_count(clamp_count), .count_clr(count_clr)
    );

    act_unit_mc #(
        .DATA_WIDTH(16), .FRACTION(14), .LANES(4), .LEAK_SHIFT(3), .COUNT_WIDTH(4)
    ) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sm_in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_cap(in_cap),
        .out_valid(sm_out_valid), .out_ready(out_ready), .out_data(sm_out_data),
        .clamp_count(sm_count), .count_clr(count_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one beat with out_ready high; check acceptance, 2-cycle latency and result.
    task automatic send_beat(input string tag, input logic [63:0] d, input logic [1:0] m,
                             input logic [15:0] c, input logic [63:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_cap   = c;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_not_yet"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp);
    endtask

    function automatic logic [63:0] bp_data(input int k);
        logic [15:0] kk;
        kk = k[15:0];
        return {16'h4000 + kk, 16'h3000 + kk, 16'h2000 + kk, 16'h1000 + kk};
    endfunction

    initial begin
        int          sent;
        int          recv;
        bit          seen_stall;
        bit          prev_stall;
        bit          acc;
        bit          oacc;
        logic [63:0] prev_data;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        in_cap    = '0;
        out_ready = 1'b1;
        count_clr = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_count", clamp_count, 0);
        rst = 1'b0;

        // Lanes packed lane0 in the low bits.
        send_beat("relu", 64'h7FFF_0000_C000_4000, 2'd1, 16'h0000, 64'h7FFF_0000_0000_4000);
        chk("relu_count", clamp_count, 1);

        send_beat("pass", 64'h8000_7FFF_0001_FFFF, 2'd0, 16'h0000, 64'h8000_7FFF_0001_FFFF);
        chk("pass_count", clamp_count, 1);

        send_beat("leaky", 64'h8000_2000_FFFD_C000, 2'd2, 16'h0000, 64'hF000_2000_FFFF_F800);
        chk("leaky_count", clamp_count, 1);

        send_beat("clip", 64'h4000_E000_3000_6000, 2'd3, 16'h4000, 64'h4000_0000_3000_4000);
        chk("clip_count", clamp_count, 2);

        send_beat("clip_neg", 64'h4000_E000_3000_6000, 2'd3, 16'hFFFF, 64'h0);
        chk("clip_neg_count", clamp_count, 6);
        chk("small_count6", sm_count, 6);

        // Cap of zero with zero-valued lanes: only the nonzero lanes count.
        send_beat("clip_zero", 64'h0000_0005_0000_FFF0, 2'd3, 16'h0000, 64'h0);
        chk("clip_zero_count", clamp_count, 8);
        chk("small_count8", sm_count, 8);

        send_beat("sat1", 64'h1111_2222_3333_4444, 2'd3, 16'h8000, 64'h0);
        chk("sat1_small", sm_count, 12);
        send_beat("sat2", 64'h1111_2222_3333_4444, 2'd3, 16'h8000, 64'h0);
        chk("sat2_small", sm_count, 15);
        send_beat("sat3", 64'h1111_2222_3333_4444, 2'd3, 16'h8000, 64'h0);
        chk("sat3_small", sm_count, 15);
        chk("sat3_big", clamp_count, 20);

        // Clear on the same cycle the clamping beat enters stage 2.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {4{16'hE000}};
        in_mode  = 2'd3;
        in_cap   = 16'hFFFF;
        @(negedge clk);
        in_valid  = 1'b0;
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        chk("clr_valid", out_valid, 1);
        chk("clr_data", out_data, 64'h0);
        chk("clr_big", clamp_count, 0);
        chk("clr_small", sm_count, 0);

        // Backpressure: in_valid held high, out_ready low for cycles 3..6.
        sent       = 0;
        recv       = 0;
        seen_stall = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 8);
            in_data   = bp_data(sent);
            in_mode   = 2'd0;
            in_cap    = 16'h0000;
            #1;
            if (prev_stall) chk("bp_hold", out_data, prev_data);
            if (in_valid && !in_ready) seen_stall = 1'b1;
            acc  = in_valid && in_ready;
            oacc = out_valid && out_ready;
            if (oacc) begin
                chk("bp_order", out_data, bp_data(recv));
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_recv", 64'(recv), 8);
        chk("bp_sent", 64'(sent), 8);
        chk("bp_stall_seen", seen_stall, 1);
        @(negedge clk);
        chk("bp_no_dup", out_valid, 0);
        chk("bp_count", clamp_count, 0);

        // Fill both stages, then reset mid-stream.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {4{16'hC000}};
        in_mode   = 2'd1;
        in_cap    = 16'h0000;
        @(negedge clk);
        in_data   = 64'h0001_0002_0003_0004;
        @(negedge clk);
        in_valid  = 1'b0;
        chk("mid_full_valid", out_valid, 1);
        chk("mid_full_in_ready", in_ready, 0);
        chk("mid_count", clamp_count, 4);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 64'h0);
        chk("mid_rst_count", clamp_count, 0);

        send_beat("post_rst", 64'h7FFF_0000_C000_4000, 2'd1, 16'h0000, 64'h7FFF_0000_0000_4000);
        chk("post_rst_count", clamp_count, 1);
        @(negedge clk);
        chk("post_rst_drain", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/act_unit_mc.md
Name: act_unit_mc

Overview:
- Multi-lane, multi-mode fixed-point activation stage; successor to the single-lane ReLU.
- Applies one of four activations (pass, ReLU, leaky ReLU, clipped ReLU) to LANES signed Q(DATA_WIDTH-FRACTION).FRACTION values per beat.
- Two-stage pipeline with valid/ready backpressure and a saturating count of zero-clamped lanes.
- Sits between the MAC/dequant output of each encoder/decoder layer and the next layer's input buffer.

Parameters:
- DATA_WIDTH, 16: bits per lane, two's complement.
- FRACTION, 14: fractional bits. Informational only, because all arithmetic is width-preserving.
- LANES, 4: lanes per beat.
- LEAK_SHIFT, 3: leaky slope = 2^-LEAK_SHIFT, applied as an arithmetic right shift.
- COUNT_WIDTH, 32: width of the clamp counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_data  in  LANES*DATA_WIDTH  lane i is in_data[i*DATA_WIDTH +: DATA_WIDTH].
- in_mode  in  2  activation mode, sampled with the beat.
- in_cap  in  DATA_WIDTH  signed clip ceiling for CLIP mode, sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*DATA_WIDTH  activated lanes, same packing as in_data.
- clamp_count  out  COUNT_WIDTH  lanes forced to zero since reset or clear.
- count_clr  in  1  synchronous clear of clamp_count.

Behaviour:
- Reset:
  - s1_valid, s2_valid, out_valid = 0; out_data = 0; clamp_count = 0.
  - in_ready = 0 while rst is high.
  - A reset mid-stream discards in-flight beats with no output.
- Handshake:
  - A beat transfers on in_valid && in_ready, or on out_valid && out_ready.
  - s2_en = !s2_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en && !rst, a combinational path from out_ready.
  - out_valid = s2_valid. While out_valid && !out_ready, out_data holds stable.
- Stage 1: on s1_en, registers data, mode and cap, and sets s1_valid = in_valid && in_ready.
- Stage 2: on s2_en, registers the computed lanes and sets s2_valid = s1_valid.
- Latency and throughput:
  - A beat accepted at edge N is visible on out_data after edge N+1 (out_valid high in the cycle following N+1).
  - Throughput is 1 beat per cycle with no bubbles under continuous out_ready.
- Per-lane function, with x signed:
  - PASS (0): y = x.
  - RELU (1): y = (x < 0) ? 0 : x.
  - LEAKY (2): y = (x < 0) ? x >>> LEAK_SHIFT : x. The shift floors toward minus infinity. No rounding and no overflow are possible.
  - CLIP (3): y = (x < 0) ? 0 : min(x, cap). If cap <= 0, y = 0 for all lanes.
  - Output width equals input width. No saturation is needed.
- Clamp counter:
  - A lane "clamps" when the mode is RELU or CLIP and y is forced to 0 by x < 0 or cap <= 0. A lane whose input x is already 0 does not count.
  - On each stage-2 load of a valid beat, clamp_count += (number of clamped lanes), 0..LANES.
  - The counter saturates at 2^COUNT_WIDTH-1.
  - count_clr has priority: count_clr in the same cycle as an increment gives 0, and that beat's contribution is dropped.
- Mode and cap changes between beats are allowed. Each beat uses its own sampled mode and cap.
- Mode values outside 0..3 cannot occur because the field is 2 bits.

Decomposition:
- Package act_pkg:
  - typedef enum logic [1:0] act_mode_e {ACT_PASS, ACT_RELU, ACT_LEAKY, ACT_CLIP}.
  - Helper function popcount of the clamp flags.
- Sub-module act_lane: combinational, one lane. Inputs x, mode, cap. Outputs y and clamped.
  - Instantiated LANES times by a generate loop between stage 1 and stage 2.
- The top module holds the pipeline registers, the handshake and the counter.

Test Plan:
- RELU, LANES=4, lanes {0x4000, 0xC000, 0x0000, 0x7FFF}, out_ready=1:
  - out {0x4000, 0x0000, 0x0000, 0x7FFF}.
  - out_valid 2 cycles after acceptance.
  - clamp_count = 1.
- LEAKY, lanes {0xC000, 0xFFFD, 0x2000, 0x8000}:
  - out {0xF800, 0xFFFF, 0x2000, 0xF000}.
  - clamp_count unchanged.
- CLIP with cap=0x4000, lanes {0x6000, 0x3000, 0xE000, 0x4000}:
  - out {0x4000, 0x3000, 0x0000, 0x4000}.
  - clamp +1.
  - Repeat with cap=0xFFFF: all outputs 0, clamp +4.
- Backpressure: stream 8 beats with in_valid held high and out_ready low for cycles 3-6:
  - in_ready drops once both stages are full.
  - out_data is held stable.
  - No beat is lost or duplicated, and order is preserved.
- Counter edges:
  - Preload near max by forcing COUNT_WIDTH=4; 4 clamping beats → clamp_count sticks at 15.
  - Assert count_clr together with a clamping beat → clamp_count = 0.
- Reset mid-stream: assert rst for 1 cycle with both stages valid:
  - out_valid = 0 and out_data = 0 next cycle.
  - clamp_count = 0.
  - The first post-reset beat appears with normal 2-cycle latency.
